// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

  typedef enum logic [1:0] {StIdle, StXfer, StWb} state_e;

  typedef enum logic [1:0] {AmodeIa, AmodeIb, AmodeDa, AmodeDb} amode_e;

  localparam logic [3:0] RegPc = 4'd15;
  localparam int unsigned WordBytes = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a 16-bit register list.
module lowest_set_bit (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);

  // Scan downwards so the lowest set bit is the last to win.
  always_comb begin
    idx_o = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 4'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list, one register-file/memory transfer per handshake.
// Optional abort support is enabled by defining LDM_STM_ABORT_EN (adds abort_i / aborted_o).
module ldm_stm_sequencer
  import ldm_stm_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic         load_i,
  input  logic [1:0]   amode_i,
  input  logic         writeback_i,
  input  logic [3:0]   base_reg_i,
  input  logic [15:0]  reg_list_i,
  input  logic [N-1:0] base_addr_i,
`ifdef LDM_STM_ABORT_EN
  input  logic         abort_i,
  output logic         aborted_o,
`endif
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o,
  output logic [3:0]   rf_read_addr_o,
  input  logic [N-1:0] rf_read_data_i,
  output logic [3:0]   rf_write_addr_o,
  output logic [N-1:0] rf_write_data_o,
  output logic         rf_write_enable_o,
  output logic         mem_valid_o,
  input  logic         mem_ready_i,
  output logic         mem_write_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_wdata_o,
  input  logic [N-1:0] mem_rdata_i
);

  state_e       state_q;
  logic [15:0]  list_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] final_q;
  logic         load_q;
  logic         wb_go_q;
  logic [3:0]   base_reg_q;
  logic         done_q;

  logic [4:0]   cnt;
  logic [N-1:0] span;
  logic [N-1:0] word;
  logic [N-1:0] first_addr;
  logic [N-1:0] final_base;
  logic [3:0]   cur_reg;
  logic         list_any;
  logic [15:0]  list_next;
  logic         hs;
  logic         abort_req;

  lowest_set_bit u_lsb (
    .vec_i (list_q),
    .idx_o (cur_reg),
    .any_o (list_any)
  );

  assign cnt  = popcount16(reg_list_i);
  assign span = N'({cnt, 2'b00});
  assign word = N'(WordBytes);

  always_comb begin
    first_addr = base_addr_i;
    final_base = base_addr_i + span;
    unique case (amode_i)
      AmodeIa: first_addr = base_addr_i;
      AmodeIb: first_addr = base_addr_i + word;
      AmodeDa: begin
        first_addr = base_addr_i - span + word;
        final_base = base_addr_i - span;
      end
      AmodeDb: begin
        first_addr = base_addr_i - span;
        final_base = base_addr_i - span;
      end
      default: ;
    endcase
  end

  assign list_next = list_q & ~(16'd1 << cur_reg);
  assign hs        = (state_q == StXfer) && mem_ready_i;

`ifdef LDM_STM_ABORT_EN
  logic aborted_q;
  assign abort_req = abort_i;
  assign aborted_o = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      list_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      load_q     <= 1'b0;
      wb_go_q    <= 1'b0;
      base_reg_q <= '0;
      done_q     <= 1'b0;
`ifdef LDM_STM_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef LDM_STM_ABORT_EN
      aborted_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            load_q     <= load_i;
            base_reg_q <= base_reg_i;
            list_q     <= reg_list_i;
            addr_q     <= first_addr;
            final_q    <= final_base;
            // A loaded base register beats the written-back address.
            wb_go_q    <= writeback_i && !(load_i && reg_list_i[base_reg_i]);
            if (reg_list_i == '0) done_q  <= 1'b1;
            else                  state_q <= StXfer;
          end
        end
        StXfer: begin
          if (hs) begin
            list_q <= list_next;
            addr_q <= addr_q + word;
          end
          if (abort_req) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
`ifdef LDM_STM_ABORT_EN
            aborted_q <= 1'b1;
`endif
          end else if (hs && list_next == '0) begin
            if (wb_go_q) begin
              state_q <= StWb;
            end else begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        StWb: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rf_read_addr_o    = '0;
    rf_write_addr_o   = '0;
    rf_write_data_o   = '0;
    rf_write_enable_o = 1'b0;
    error_o           = 1'b0;
    if (state_q == StXfer) begin
      if (!load_q) begin
        rf_read_addr_o = cur_reg;
      end else if (mem_ready_i) begin
        if (cur_reg == RegPc) begin
          error_o = 1'b1;
        end else begin
          rf_write_enable_o = 1'b1;
          rf_write_addr_o   = cur_reg;
          rf_write_data_o   = mem_rdata_i;
        end
      end
    end else if (state_q == StWb) begin
      if (base_reg_q == RegPc) begin
        error_o = 1'b1;
      end else begin
        rf_write_enable_o = 1'b1;
        rf_write_addr_o   = base_reg_q;
        rf_write_data_o   = final_q;
      end
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign mem_valid_o = (state_q == StXfer) && list_any;
  assign mem_write_o = mem_valid_o && !load_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = mem_write_o ? rf_read_data_i : '0;

endmodule
